// File: rtl/gsim_pkg.sv
// Shared constants and state encoding for the banded Gauss-Seidel solver.
package gsim_pkg;

  localparam int C_DIAG    = 20;
  localparam int C_N1      = 13;
  localparam int C_N2      = 6;
  localparam int C_N3      = 1;
  localparam int FRAC_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_OUT
  } state_t;

endpackage

// File: rtl/gsim_div20.sv
// Combinational exact floor(num/20) using a reciprocal multiply, a remainder
// correction and saturation to the XW-bit signed solution range.
module gsim_div20
  import gsim_pkg::*;
#(
  parameter int XW = 32
) (
  input  logic signed [XW+5:0] num,
  output logic signed [XW-1:0] q
);

  localparam int NW = XW + 6;
  localparam int SH = NW + 2;
  localparam int PW = NW + SH + 1;

  // floor(2^SH/20): the estimate below lands within one of the true quotient
  localparam logic [SH:0]          POW   = {1'b1, {SH{1'b0}}};
  localparam logic [SH:0]          RECIP = POW / (SH + 1)'(C_DIAG);
  localparam logic signed [PW-1:0] RCX   = PW'(RECIP);
  localparam logic signed [NW:0]   K20   = (NW + 1)'(C_DIAG);
  localparam logic signed [NW-1:0] ONE   = NW'(1);

  function automatic logic signed [NW-1:0] floor_fix(
    input logic signed [NW-1:0] q_est,
    input logic signed [NW:0]   rem
  );
    if (rem < 0)         return q_est - ONE;
    else if (rem >= K20) return q_est + ONE;
    else                 return q_est;
  endfunction

  function automatic logic signed [XW-1:0] sat_xw(input logic signed [NW-1:0] v);
    logic signed [NW-1:0] vmax;
    logic signed [NW-1:0] vmin;
    vmax = NW'($signed({1'b0, {(XW-1){1'b1}}}));
    vmin = NW'($signed({1'b1, {(XW-1){1'b0}}}));
    if (v > vmax)      return {1'b0, {(XW-1){1'b1}}};
    else if (v < vmin) return {1'b1, {(XW-1){1'b0}}};
    else               return v[XW-1:0];
  endfunction

  logic signed [PW-1:0] num_x;
  logic signed [NW-1:0] q_est;
  logic signed [NW:0]   rem;
  logic signed [NW-1:0] q_fix;

  always_comb begin
    num_x = PW'(num);
    q_est = NW'((num_x * RCX) >>> SH);
    rem   = (NW + 1)'(num) - (NW + 1)'(q_est) * K20;
    q_fix = floor_fix(q_est, rem);
    q     = sat_xw(q_fix);
  end

endmodule

// File: rtl/gsim_solver.sv
// Iterative Gauss-Seidel solver for the 7-point symmetric band stencil:
// loads b[], sweeps in place until converged or capped, then streams x[].
module gsim_solver
  import gsim_pkg::*;
#(
  parameter int N  = 16,
  parameter int BW = 16,
  parameter int XW = 32,
  parameter int IW = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_en,
  input  logic [BW-1:0]         b_in,
  input  logic [IW-1:0]         iter_max,
  input  logic [XW-1:0]         tol,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         x_out,
  output logic [$clog2(N)-1:0]  out_idx,
  output logic                  converged,
  output logic [IW-1:0]         iter_count
);

  localparam int IDXW = $clog2(N);
  localparam int NW   = XW + 6;

  localparam logic signed [NW-1:0] K13 = NW'(C_N1);
  localparam logic signed [NW-1:0] K6  = NW'(C_N2);
  localparam logic signed [NW-1:0] K1  = NW'(C_N3);

  state_t               state, state_nxt;
  logic [IDXW-1:0]      idx;
  logic signed [XW-1:0] x [N];
  logic signed [BW-1:0] b [N];
  logic [IW-1:0]        iter_max_q;
  logic [XW-1:0]        tol_q;
  logic [XW:0]          maxd;

  logic                 last_idx;
  logic signed [NW-1:0] xm1, xp1, xm2, xp2, xm3, xp3, bx, num;
  logic signed [XW-1:0] x_new, x_old;
  logic signed [XW:0]   diff;
  logic [XW:0]          absd, maxd_cur;
  logic                 conv_hit, cap_hit;
  int                   ii;

  // Out-of-range neighbours contribute nothing; in-place storage gives
  // Gauss-Seidel ordering (lower indices already hold this sweep's values).
  function automatic logic signed [NW-1:0] nb(input int k);
    if (k < 0 || k >= N) return '0;
    return NW'(x[k[IDXW-1:0]]);
  endfunction

  assign last_idx = (idx == IDXW'(N - 1));

  always_comb begin
    ii    = int'(idx);
    xm1   = nb(ii - 1);
    xp1   = nb(ii + 1);
    xm2   = nb(ii - 2);
    xp2   = nb(ii + 2);
    xm3   = nb(ii - 3);
    xp3   = nb(ii + 3);
    bx    = NW'($signed({b[idx], {FRAC_BITS{1'b0}}}));
    num   = bx + K13 * (xm1 + xp1) - K6 * (xm2 + xp2) + K1 * (xm3 + xp3);
  end

  gsim_div20 #(.XW(XW)) u_div20 (
    .num (num),
    .q   (x_new)
  );

  always_comb begin
    x_old    = x[idx];
    diff     = {x_new[XW-1], x_new} - {x_old[XW-1], x_old};
    absd     = diff[XW] ? (~diff + 1'b1) : diff;
    maxd_cur = (idx == '0 || absd > maxd) ? absd : maxd;
    conv_hit = (maxd_cur <= {1'b0, tol_q});
    cap_hit  = ((iter_count + 1'b1) == iter_max_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_en) state_nxt = S_LOAD;
      S_LOAD:  if (in_en && last_idx) state_nxt = S_SWEEP;
      S_SWEEP: if (last_idx && (conv_hit || cap_hit)) state_nxt = S_OUT;
      S_OUT:   if (out_ready && last_idx) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      iter_max_q <= '0;
      tol_q      <= '0;
      maxd       <= '0;
      converged  <= 1'b0;
      iter_count <= '0;
      x          <= '{default: '0};
      b          <= '{default: '0};
    end else begin
      case (state)
        S_IDLE: begin
          if (in_en) begin
            b[0]       <= b_in;
            iter_max_q <= (iter_max == '0) ? IW'(1) : iter_max;
            tol_q      <= tol;
            x          <= '{default: '0};
            converged  <= 1'b0;
            iter_count <= '0;
            idx        <= IDXW'(1);
          end
        end
        S_LOAD: begin
          if (in_en) begin
            b[idx] <= b_in;
            idx    <= last_idx ? '0 : idx + 1'b1;
          end
        end
        S_SWEEP: begin
          x[idx] <= x_new;
          maxd   <= maxd_cur;
          if (last_idx) begin
            iter_count <= iter_count + 1'b1;
            converged  <= conv_hit;
            idx        <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) idx <= last_idx ? '0 : idx + 1'b1;
        end
        default: idx <= '0;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);
  assign out_idx   = out_valid ? idx : '0;
  assign x_out     = out_valid ? x[idx] : '0;

endmodule

// File: tb/tb_gsim_solver.sv
// Randomised directed bench for gsim_solver (N=16 and N=8 instances) checked
// against a plain-arithmetic Gauss-Seidel reference model.
module tb_gsim_solver;

  localparam longint XMAX = 64'sd2147483647;
  localparam longint XMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_en = 1'b0;
  logic [15:0] b_in = '0;
  logic [6:0]  iter_max = '0;
  logic [31:0] tol = '0;
  logic        out_ready = 1'b0;
  logic        use8 = 1'b0;

  logic        busy16, oval16, conv16, busy8, oval8, conv8;
  logic [31:0] xo16, xo8;
  logic [3:0]  oidx16;
  logic [2:0]  oidx8;
  logic [6:0]  itc16, itc8;

  logic        busy, out_valid, converged;
  logic [31:0] x_out;
  logic [3:0]  out_idx;
  logic [6:0]  iter_count;

  int total = 0;
  int bad   = 0;

  longint      mb [64];
  longint      mx [64];
  int          m_iters;
  bit          m_conv;
  logic [31:0] obs [64];

  gsim_solver #(.N(16), .BW(16), .XW(32), .IW(7)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .in_en(in_en), .b_in(b_in),
    .iter_max(iter_max), .tol(tol), .busy(busy16), .out_valid(oval16),
    .out_ready(out_ready), .x_out(xo16), .out_idx(oidx16),
    .converged(conv16), .iter_count(itc16)
  );

  gsim_solver #(.N(8), .BW(16), .XW(32), .IW(7)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_en(in_en), .b_in(b_in),
    .iter_max(iter_max), .tol(tol), .busy(busy8), .out_valid(oval8),
    .out_ready(out_ready), .x_out(xo8), .out_idx(oidx8),
    .converged(conv8), .iter_count(itc8)
  );

  assign busy       = use8 ? busy8 : busy16;
  assign out_valid  = use8 ? oval8 : oval16;
  assign converged  = use8 ? conv8 : conv16;
  assign x_out      = use8 ? xo8 : xo16;
  assign out_idx    = use8 ? {1'b0, oidx8} : oidx16;
  assign iter_count = use8 ? itc8 : itc16;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] xv32(input longint v);
    return v[31:0];
  endfunction

  function automatic longint mnb(input int k, input int n);
    if (k < 0 || k >= n) return 0;
    return mx[k];
  endfunction

  // Reference: whole sweeps with exact floor division and saturation.
  task automatic model_solve(input int n, input int imax, input logic [31:0] tolv);
    longint num, q, d, maxd;
    int cap;
    cap = (imax == 0) ? 1 : imax;
    for (int i = 0; i < 64; i++) mx[i] = 0;
    m_iters = 0;
    m_conv  = 0;
    while (m_iters < cap && !m_conv) begin
      maxd = 0;
      for (int i = 0; i < n; i++) begin
        num = mb[i] * 65536
            + 13 * (mnb(i - 1, n) + mnb(i + 1, n))
            - 6  * (mnb(i - 2, n) + mnb(i + 2, n))
            +      (mnb(i - 3, n) + mnb(i + 3, n));
        q = num / 20;
        if ((num % 20) != 0 && num < 0) q = q - 1;
        if (q > XMAX) q = XMAX;
        if (q < XMIN) q = XMIN;
        d = (q > mx[i]) ? q - mx[i] : mx[i] - q;
        if (d > maxd) maxd = d;
        mx[i] = q;
      end
      m_iters++;
      if (maxd <= longint'(tolv)) m_conv = 1;
    end
  endtask

  task automatic do_reset();
    in_en = 0; out_ready = 0; b_in = '0;
    @(negedge clk);
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic load_b(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_en = 0;
          @(negedge clk);
        end
      end
      in_en = 1;
      b_in  = 16'(mb[i]);
      @(negedge clk);
    end
    in_en = 0;
  endtask

  task automatic collect(input string tag, input int n, input bit rdy_rand, output int lat);
    int  got, cyc;
    bit  rdy;
    got = 0; cyc = 0; lat = -1;
    while (got < n && cyc < 20000) begin
      rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        if (lat < 0) lat = cyc + 1;
        chk($sformatf("%s_idx%0d", tag, got), 64'(out_idx), 64'(got));
        chk($sformatf("%s_x%0d", tag, got), 64'(x_out), 64'(xv32(mx[got])));
        if (rdy) begin
          obs[got] = x_out;
          got++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 0;
    chk({tag, "_count"}, 64'(got), 64'(n));
  endtask

  task automatic run_case(input string tag, input int n, input int imax, input logic [31:0] tolv,
                          input bit gaps, input bit rdy_rand, input bit pulse);
    int lat;
    model_solve(n, imax, tolv);
    iter_max = 7'(imax);
    tol      = tolv;
    load_b(n, gaps);
    iter_max = 7'd1;
    tol      = 32'hFFFF_FFFF;
    if (pulse) begin
      in_en = 1; b_in = 16'h1234;
      @(negedge clk);
      in_en = 0;
      chk({tag, "_pulse_busy"}, 64'(busy), 64'd1);
    end
    collect(tag, n, rdy_rand, lat);
    if (!rdy_rand && !pulse) chk({tag, "_latency"}, 64'(lat), 64'(n * m_iters + 1));
    chk({tag, "_iters"}, 64'(iter_count), 64'(m_iters));
    chk({tag, "_conv"}, 64'(converged), 64'(m_conv));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_oval_low"}, 64'(out_valid), 64'd0);
  endtask

  task automatic rand_b(input int n, input int span);
    for (int i = 0; i < n; i++) mb[i] = longint'($urandom_range(0, 2 * span)) - span;
  endtask

  task automatic zero_out_checks(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_oval"}, 64'(out_valid), 64'd0);
    chk({tag, "_xout"}, 64'(x_out), 64'd0);
    chk({tag, "_oidx"}, 64'(out_idx), 64'd0);
    chk({tag, "_conv"}, 64'(converged), 64'd0);
    chk({tag, "_iters"}, 64'(iter_count), 64'd0);
  endtask

  initial begin
    do_reset();
    zero_out_checks("reset");

    for (int i = 0; i < 64; i++) mb[i] = 0;
    run_case("zero", 16, 50, 32'h0, 0, 0, 0);
    chk("zero_iters_const", 64'(iter_count), 64'd1);
    chk("zero_conv_const", 64'(converged), 64'd1);
    chk("zero_x5_const", 64'(obs[5]), 64'h0);

    mb[0] = 20;
    run_case("impulse", 16, 1, 32'h0, 0, 0, 0);
    chk("impulse_x0_const", 64'(obs[0]), 64'h0001_0000);
    chk("impulse_x1_const", 64'(obs[1]), 64'h0000_A666);
    chk("impulse_conv_const", 64'(converged), 64'd0);

    mb[0] = -1;
    run_case("negfloor", 16, 1, 32'h0, 0, 0, 0);
    chk("negfloor_x0_const", 64'(obs[0]), 64'hFFFF_F333);

    rand_b(16, 8);
    run_case("cap5", 16, 5, 32'h0, 0, 0, 0);
    chk("cap5_iters_const", 64'(iter_count), 64'd5);
    run_case("tol100", 16, 120, 32'h0000_0100, 0, 0, 0);

    rand_b(16, 300);
    run_case("bp", 16, 30, 32'h0000_0100, 1, 1, 1);

    rand_b(16, 30000);
    run_case("big", 16, 3, 32'h0, 0, 0, 0);

    use8 = 1;
    do_reset();
    rand_b(8, 50);
    iter_max = 7'd50; tol = 32'h0;
    load_b(8, 0);
    repeat (12) @(negedge clk);
    chk("midsweep_busy", 64'(busy), 64'd1);
    reset_n = 0;
    #1;
    zero_out_checks("midrst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    rand_b(8, 50);
    run_case("n8_imax0", 8, 0, 32'h0, 0, 0, 0);
    chk("n8_imax0_iters_const", 64'(iter_count), 64'd1);
    rand_b(8, 50);
    run_case("n8_conv", 8, 60, 32'h0000_0040, 1, 0, 0);
    rand_b(8, 50);
    run_case("n8_bp", 8, 10, 32'h0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
